cha_gsel_ctrl: RTL

//  Sequences game switching for the CHA CPLD C-ROM address translation. Takes a game-select request,

---
 rtl/cha_gsel_if.sv | 25 ++
 rtl/cha_gsel_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cha_gsel_if.sv
// Game-select request and C-ROM table read bus for cha_gsel_ctrl.
// master: request source + table memory; slave: the controller.
interface cha_gsel_if;
  logic [7:0]  GSEL_REQ;
  logic        GSEL_STB;
  logic [7:0]  TBL_ADDR;
  logic        TBL_RD;
  logic [18:0] TBL_DATA;

  modport master (
    output GSEL_REQ,
    output GSEL_STB,
    output TBL_DATA,
    input  TBL_ADDR,
    input  TBL_RD
  );

  modport slave (
    input  GSEL_REQ,
    input  GSEL_STB,
    input  TBL_DATA,
    output TBL_ADDR,
    output TBL_RD
  );
endinterface

// File: rtl/cha_gsel_ctrl.sv
// Game switch sequencer for CHA C-ROM translation: holds cart in reset, fetches IX/MASK, settles.
// Ports: CLK/RESET (sync, active-high); bus = GSEL_REQ/STB in, TBL_ADDR/RD out, TBL_DATA in;
// GSEL/IX/MASK registered translation outputs; nRESET_OUT cart reset; BUSY level; DONE pulse.
module cha_gsel_ctrl #(
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  cha_gsel_if.slave   bus,
  output logic [7:0]  GSEL,
  output logic [11:0] IX,
  output logic [5:0]  MASK,
  output logic        nRESET_OUT,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_FETCH,
    S_CAPTURE,
    S_SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [5:0]       MASK_ALL    = 6'h3F;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       target_q, target_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_gsel_q, pend_gsel_d;
  logic [7:0]       gsel_q, gsel_d;
  logic [11:0]      ix_q, ix_d;
  logic [5:0]       mask_q, mask_d;
  logic             nrst_q, nrst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tbl_rd_q, tbl_rd_d;
  logic [7:0]       tbl_addr_q, tbl_addr_d;

  logic             tbl_valid;
  logic [5:0]       tbl_mask;
  logic [11:0]      tbl_ix;

  assign {tbl_valid, tbl_mask, tbl_ix} = bus.TBL_DATA;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    pend_d      = pend_q;
    pend_gsel_d = pend_gsel_q;
    gsel_d      = gsel_q;
    ix_d        = ix_q;
    mask_d      = mask_q;
    nrst_d      = nrst_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tbl_rd_d    = 1'b0;
    tbl_addr_d  = tbl_addr_q;

    // Any strobe outside IDLE (incl. the finishing cycle) is
    // parked; a newer one overwrites an older one.
    if (bus.GSEL_STB && state_q != S_IDLE) begin
      pend_d      = 1'b1;
      pend_gsel_d = bus.GSEL_REQ;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.GSEL_STB || pend_q) begin
          target_d = bus.GSEL_STB ? bus.GSEL_REQ : pend_gsel_q;
          pend_d   = 1'b0;
          cnt_d    = '0;
          nrst_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          // Menu: no table entry, cart stays in reset.
          if (target_q == 8'h00) begin
            gsel_d  = 8'h00;
            ix_d    = 12'h000;
            mask_d  = MASK_ALL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            tbl_rd_d   = 1'b1;
            tbl_addr_d = target_q;
            state_d    = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        gsel_d  = target_q;
        ix_d    = tbl_valid ? tbl_ix : 12'h000;
        mask_d  = tbl_valid ? tbl_mask : MASK_ALL;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          nrst_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      target_q    <= 8'h00;
      pend_q      <= 1'b0;
      pend_gsel_q <= 8'h00;
      gsel_q      <= 8'h00;
      ix_q        <= 12'h000;
      mask_q      <= MASK_ALL;
      nrst_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tbl_rd_q    <= 1'b0;
      tbl_addr_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      pend_q      <= pend_d;
      pend_gsel_q <= pend_gsel_d;
      gsel_q      <= gsel_d;
      ix_q        <= ix_d;
      mask_q      <= mask_d;
      nrst_q      <= nrst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tbl_rd_q    <= tbl_rd_d;
      tbl_addr_q  <= tbl_addr_d;
    end
  end

  assign bus.TBL_RD   = tbl_rd_q;
  assign bus.TBL_ADDR = tbl_addr_q;
  assign GSEL         = gsel_q;
  assign IX           = ix_q;
  assign MASK         = mask_q;
  assign nRESET_OUT   = nrst_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule
